// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, metadata layout and FSM states for the cache fill controller
package cache_pkg;
    localparam int TAG_W     = 6;
    localparam int SET_W     = 6;
    localparam int WORDS     = 8;
    localparam int MEM_LAT   = 4;
    localparam int WORD_W    = $clog2(WORDS);
    localparam int NUM_SETS  = 1 << SET_W;
    localparam int ADDR_W    = 16;
    localparam int META_W    = 8;
    localparam int TAG_MSB   = 7;
    localparam int LRU_BIT   = 1;
    localparam int VALID_BIT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Metadata word that marks a way valid and most recently used.
    function automatic logic [META_W-1:0] meta_mru(input logic [TAG_W-1:0] tag);
        logic [META_W-1:0] m;
        m                     = '0;
        m[TAG_MSB -: TAG_W]   = tag;
        m[LRU_BIT]            = 1'b1;
        m[VALID_BIT]          = 1'b1;
        return m;
    endfunction

    function automatic logic [NUM_SETS-1:0] onehot_set(input logic [SET_W-1:0] s);
        return {{(NUM_SETS-1){1'b0}}, 1'b1} << s;
    endfunction

    function automatic logic [WORDS-1:0] onehot_word(input logic [WORD_W-1:0] w);
        return {{(WORDS-1){1'b0}}, 1'b1} << w;
    endfunction
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - request, metadata/data array and memory signals of the fill controller
// CACHE_FILL_CTRL_STATS_EN adds the hit_count/miss_count outputs.
interface cache_fill_ctrl_if;
    import cache_pkg::*;

    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [META_W-1:0]     tag_out0;
    logic [META_W-1:0]     tag_out1;
    logic                  mem_data_valid;
    logic                  hit;
    logic                  stall;
    logic [NUM_SETS-1:0]   set_enable;
    logic [META_W-1:0]     meta_din;
    logic                  meta_write0;
    logic                  meta_write1;
    logic                  data_write0;
    logic                  data_write1;
    logic [WORDS-1:0]      word_enable;
    logic                  data_sel_mem;
    logic                  mem_read_en;
    logic [ADDR_W-1:0]     mem_addr;
`ifdef CACHE_FILL_CTRL_STATS_EN
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;
`endif

    modport master (
`ifdef CACHE_FILL_CTRL_STATS_EN
        output hit_count, miss_count,
`endif
        input  req_valid, req_write, req_addr, tag_out0, tag_out1, mem_data_valid,
        output hit, stall, set_enable, meta_din, meta_write0, meta_write1,
               data_write0, data_write1, word_enable, data_sel_mem, mem_read_en, mem_addr
    );

    modport slave (
`ifdef CACHE_FILL_CTRL_STATS_EN
        input  hit_count, miss_count,
`endif
        output req_valid, req_write, req_addr, tag_out0, tag_out1, mem_data_valid,
        input  hit, stall, set_enable, meta_din, meta_write0, meta_write1,
               data_write0, data_write1, word_enable, data_sel_mem, mem_read_en, mem_addr
    );
endinterface

// File: rtl/cache_fill_seq.sv
// rtl/cache_fill_seq.sv - block fill issue/receive counters and memory word address generation
module cache_fill_seq
    import cache_pkg::*;
#(
    parameter int N_WORDS = WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_active,
    input  logic              i_data_valid,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [SET_W-1:0]  i_set,
    output logic              o_mem_read_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_done,
    output logic [WORD_W-1:0] o_word
);
    localparam logic [WORD_W-1:0] LAST = WORD_W'(N_WORDS - 1);

    logic [WORD_W-1:0] r_issue_cnt;
    logic [WORD_W-1:0] r_recv_cnt;
    logic              r_issuing;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_issuing   <= 1'b0;
        end else if (i_start) begin
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_issuing   <= 1'b1;
        end else begin
            if (r_issuing) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
                if (r_issue_cnt == LAST)
                    r_issuing <= 1'b0;
            end
            if (i_active && i_data_valid)
                r_recv_cnt <= r_recv_cnt + 1'b1;
        end
    end

    assign o_mem_read_en = r_issuing;
    assign o_mem_addr    = r_issuing ? {i_tag, i_set, r_issue_cnt, 1'b0} : '0;
    assign o_done        = i_active && i_data_valid && (r_recv_cnt == LAST);
    assign o_word        = r_recv_cnt;
endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - 2-way set-associative hit check, victim select and read-miss block fill
// CACHE_FILL_CTRL_STATS_EN adds saturating read hit/miss counters.
module cache_fill_ctrl #(
    parameter int MEM_LAT = cache_pkg::MEM_LAT,
    parameter int WORDS   = cache_pkg::WORDS
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.master bus
);
    import cache_pkg::state_t, cache_pkg::IDLE, cache_pkg::FILL, cache_pkg::COMMIT;
    import cache_pkg::TAG_W, cache_pkg::SET_W, cache_pkg::WORD_W;
    import cache_pkg::TAG_MSB, cache_pkg::LRU_BIT, cache_pkg::VALID_BIT;
    import cache_pkg::meta_mru, cache_pkg::onehot_set, cache_pkg::onehot_word;

    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [SET_W-1:0]   r_set;
    logic               r_victim;

    logic [TAG_W-1:0]   w_req_tag;
    logic [SET_W-1:0]   w_req_set;
    logic [WORD_W-1:0]  w_req_word;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_read_miss;
    logic               w_victim;
    logic               w_done;
    logic [WORD_W-1:0]  w_word;
    logic               w_unused;

    assign w_req_tag  = bus.req_addr[15:10];
    assign w_req_set  = bus.req_addr[9:4];
    assign w_req_word = bus.req_addr[3:1];
    assign w_unused   = bus.req_addr[0];

    assign w_hit0      = bus.tag_out0[VALID_BIT] && (bus.tag_out0[TAG_MSB -: TAG_W] == w_req_tag);
    assign w_hit1      = bus.tag_out1[VALID_BIT] && (bus.tag_out1[TAG_MSB -: TAG_W] == w_req_tag);
    assign w_hit       = (r_state == IDLE) && bus.req_valid && (w_hit0 || w_hit1);
    assign w_read_miss = (r_state == IDLE) && bus.req_valid && !bus.req_write && !(w_hit0 || w_hit1);

    // Invalid way first (way0 first), then the way flagged LRU; ties go to way0.
    assign w_victim = !bus.tag_out0[VALID_BIT] ? 1'b0 :
                      !bus.tag_out1[VALID_BIT] ? 1'b1 :
                      (bus.tag_out1[LRU_BIT] && !bus.tag_out0[LRU_BIT]);

    cache_fill_seq #(
        .N_WORDS (WORDS)
    ) u_seq (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (w_read_miss),
        .i_active      (r_state == FILL),
        .i_data_valid  (bus.mem_data_valid),
        .i_tag         (r_tag),
        .i_set         (r_set),
        .o_mem_read_en (bus.mem_read_en),
        .o_mem_addr    (bus.mem_addr),
        .o_done        (w_done),
        .o_word        (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tag    <= '0;
            r_set    <= '0;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_read_miss) begin
                        r_tag    <= w_req_tag;
                        r_set    <= w_req_set;
                        r_victim <= w_victim;
                        r_state  <= FILL;
                    end
                end
                FILL:    if (w_done) r_state <= COMMIT;
                COMMIT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Metadata strobes are masked during rst so an aborted fill never commits.
    always_comb begin
        bus.hit          = w_hit;
        bus.stall        = (r_state != IDLE) || w_read_miss;
        bus.set_enable   = '0;
        bus.meta_din     = '0;
        bus.meta_write0  = 1'b0;
        bus.meta_write1  = 1'b0;
        bus.data_write0  = 1'b0;
        bus.data_write1  = 1'b0;
        bus.word_enable  = '0;
        bus.data_sel_mem = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    bus.set_enable = onehot_set(w_req_set);
                    if (w_hit) begin
                        bus.meta_din    = meta_mru(w_req_tag);
                        bus.meta_write0 = w_hit0 && !rst;
                        bus.meta_write1 = !w_hit0 && !rst;
                        if (bus.req_write) begin
                            bus.data_write0 = w_hit0;
                            bus.data_write1 = !w_hit0;
                            bus.word_enable = onehot_word(w_req_word);
                        end
                    end
                end
            end
            FILL: begin
                bus.set_enable = onehot_set(r_set);
                if (bus.mem_data_valid) begin
                    bus.data_write0  = !r_victim;
                    bus.data_write1  = r_victim;
                    bus.word_enable  = onehot_word(w_word);
                    bus.data_sel_mem = 1'b1;
                end
            end
            COMMIT: begin
                bus.set_enable  = onehot_set(r_set);
                bus.meta_din    = meta_mru(r_tag);
                bus.meta_write0 = !r_victim && !rst;
                bus.meta_write1 = r_victim && !rst;
            end
            default: ;
        endcase
    end

`ifdef CACHE_FILL_CTRL_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && !bus.req_write && (r_hit_count != 16'hFFFF))
                r_hit_count <= r_hit_count + 16'd1;
            if (w_read_miss && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - directed vector bench for cache_fill_ctrl with metadata array and memory models
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic m_clear;
    always #5 clk = ~clk;

    cache_fill_ctrl_if bus();

    cache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [TAG_W-1:0]   m_tag [NUM_SETS][2];
    logic               m_val [NUM_SETS][2];
    logic               m_lru [NUM_SETS][2];
    logic [MEM_LAT-1:0] mem_sr;
    int                 idx;

    always_comb begin
        idx = 0;
        for (int i = 0; i < NUM_SETS; i++)
            if (bus.set_enable[i]) idx = i;
    end

    assign bus.tag_out0       = {m_tag[idx][0], m_lru[idx][0], m_val[idx][0]};
    assign bus.tag_out1       = {m_tag[idx][1], m_lru[idx][1], m_val[idx][1]};
    assign bus.mem_data_valid = mem_sr[MEM_LAT-1];

    // Metadata array: a write with lru_change marks the written way MRU and the other way LRU.
    always @(posedge clk) begin
        if (m_clear) begin
            mem_sr <= '0;
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < 2; w++) begin
                    m_tag[s][w] <= '0;
                    m_val[s][w] <= 1'b0;
                    m_lru[s][w] <= 1'b0;
                end
        end else begin
            mem_sr <= {mem_sr[MEM_LAT-2:0], bus.mem_read_en};
            if (bus.meta_write0 || bus.meta_write1) begin
                m_tag[idx][bus.meta_write1] <= bus.meta_din[7:2];
                m_val[idx][bus.meta_write1] <= bus.meta_din[0];
                if (bus.meta_din[1]) begin
                    m_lru[idx][bus.meta_write1]  <= 1'b0;
                    m_lru[idx][!bus.meta_write1] <= 1'b1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] pack(input logic h, input logic s, input logic dw0, input logic dw1,
                                         input logic [7:0] we, input logic dsm, input logic mw0, input logic mw1,
                                         input logic [7:0] mdin, input logic mre, input logic [15:0] ma);
        return {h, s, dw0, dw1, we, dsm, mw0, mw1, mdin, mre, ma};
    endfunction

    function automatic logic [39:0] outs();
        return pack(bus.hit, bus.stall, bus.data_write0, bus.data_write1, bus.word_enable, bus.data_sel_mem,
                    bus.meta_write0, bus.meta_write1, bus.meta_din, bus.mem_read_en, bus.mem_addr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read request in cycle 0, then fill cycles 1..13 and the re-presented hit in cycle 14.
    task automatic run_fill(input logic [15:0] a, input logic v, input int rst_cyc);
        logic [5:0]  tg;
        logic [63:0] se;
        logic        rx, cm, iss;
        logic [2:0]  ic;
        logic [39:0] exp;
        tg = a[15:10];
        se = 64'd1 << a[9:4];
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        #4;
        chk($sformatf("miss_%h_c0", a), outs(), pack(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0));
        chk($sformatf("miss_%h_set", a), bus.set_enable, se);
        for (int k = 1; k <= 13; k++) begin
            step();
            bus.req_addr = 16'hFFFF;
            if (k == rst_cyc) rst = 1'b1;
            #4;
            rx  = (k >= 5) && (k <= 12);
            cm  = (k == 13);
            iss = (k <= 8);
            ic  = 3'(k - 1);
            exp = pack(0, 1, rx && !v, rx && v, rx ? (8'd1 << (k - 5)) : 8'h00, rx,
                       cm && !v, cm && v, cm ? {tg, 2'b11} : 8'h00,
                       iss, iss ? {a[15:4], ic, 1'b0} : 16'h0);
            chk($sformatf("fill_%h_c%0d", a, k), outs(), exp);
            chk($sformatf("fill_%h_set_c%0d", a, k), bus.set_enable, se);
            if (k == rst_cyc) begin
                step();
                rst = 1'b0;
                bus.req_valid = 1'b0;
                #4;
                chk("rst_mid_fill_outs", outs(), 40'h0);
                chk("rst_mid_fill_set", bus.set_enable, 64'h0);
                step();
                return;
            end
        end
        step();
        bus.req_addr = a;
        #4;
        chk($sformatf("rehit_%h_c14", a), outs(),
            pack(1, 0, 0, 0, 8'h00, 0, !v, v, {tg, 2'b11}, 0, 16'h0));
        step();
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        logic        rv;
        logic        rw;
        logic [15:0] a;
        logic [39:0] exp;
        logic [63:0] se;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 16'h563E, pack(1, 0, 0, 1, 8'h80, 0, 0, 1, 8'h57, 0, 16'h0), 64'd1 << 35};
        tbl[1] = '{1'b1, 1'b0, 16'h1234, pack(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h13, 0, 16'h0), 64'd1 << 35};
        tbl[2] = '{1'b1, 1'b1, 16'h1236, pack(1, 0, 1, 0, 8'h08, 0, 1, 0, 8'h13, 0, 16'h0), 64'd1 << 35};
        tbl[3] = '{1'b1, 1'b1, 16'h7E34, pack(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0), 64'd1 << 35};
        tbl[4] = '{1'b0, 1'b0, 16'h1234, pack(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0), 64'd0};
        tbl[5] = '{1'b1, 1'b1, 16'h0008, pack(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0), 64'd1};

        rst           = 1'b1;
        m_clear       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        m_clear = 1'b0;
        rst     = 1'b0;
        #4;
        chk("reset_outs", outs(), 40'h0);
        chk("reset_set", bus.set_enable, 64'h0);
        step();

        run_fill(16'h1234, 1'b0, -1);
        run_fill(16'h5634, 1'b1, -1);

        for (int i = 0; i < 6; i++) begin
            bus.req_valid = tbl[i].rv;
            bus.req_write = tbl[i].rw;
            bus.req_addr  = tbl[i].a;
            #4;
            chk($sformatf("vec%0d_outs", i), outs(), tbl[i].exp);
            chk($sformatf("vec%0d_set", i), bus.set_enable, tbl[i].se);
            step();
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;

        run_fill(16'h9A34, 1'b1, -1);

        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h1234;
        #4;
        chk("way0_survives_evict", outs(), pack(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h13, 0, 16'h0));
        step();
        bus.req_valid = 1'b0;

        run_fill(16'h4C50, 1'b0, 6);
        repeat (8) step();
        run_fill(16'h4C50, 1'b0, -1);

`ifdef CACHE_FILL_CTRL_STATS_EN
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #4;
        chk("stats_reset_hits", 64'(bus.hit_count), 64'd0);
        chk("stats_reset_misses", 64'(bus.miss_count), 64'd0);
        step();
        run_fill(16'h0040, 1'b0, -1);
        run_fill(16'h0060, 1'b0, -1);
        run_fill(16'h0070, 1'b0, -1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0040;
        step();
        step();
        bus.req_valid = 1'b0;
        #4;
        chk("stats_hits_5", 64'(bus.hit_count), 64'd5);
        chk("stats_misses_3", 64'(bus.miss_count), 64'd3);
        step();
        bus.req_valid = 1'b1;
        repeat (65540) step();
        bus.req_valid = 1'b0;
        #4;
        chk("stats_hit_saturate", 64'(bus.hit_count), 64'hFFFF);
        chk("stats_misses_hold", 64'(bus.miss_count), 64'd3);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Controller for one 2-way set-associative cache. Per request it checks for a hit against the 2-way tag/LRU/valid metadata array. On a read miss it selects a victim way and fetches the 8-word block from the pipelined main memory into the data array. It then commits the tag, valid bit and LRU update back to the metadata array. One instance sits in front of each of the I-cache and D-cache.

## Interface
- Parameters:
  - MEM_LAT, 4, cycles from mem_read_en to the matching mem_data_valid.
  - WORDS, 8, 16-bit words per block.
- Ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
  - req_valid  in  1  request present.
  - req_write  in  1  request is a store.
  - req_addr  in  16  byte address: tag [15:10], set [9:4], word [3:1].
  - tag_out0, tag_out1  in  8  metadata of the enabled set: {tag[5:0], lru, valid}.
  - mem_data_valid  in  1  returned word present.
  - hit  out  1  request hits in this cycle.
  - stall  out  1  pipeline must hold the request.
  - set_enable  out  64  one-hot set select for the data and metadata arrays.
  - meta_din  out  8  {tag, lru_change, valid_set}.
  - meta_write0, meta_write1  out  1  metadata way write strobes.
  - data_write0, data_write1  out  1  data way write strobes.
  - word_enable  out  8  one-hot word select.
  - data_sel_mem  out  1  data array input comes from memory (1) or from the store data (0).
  - mem_read_en  out  1  issue a memory read.
  - mem_addr  out  16  memory word address.

## Operation
- States: IDLE, FILL, COMMIT.
- IDLE, with req_valid:
  - set_enable = onehot(req_addr[9:4]).
  - A way hits when valid=1 and its tag matches req_addr[15:10]. Both ways hitting is illegal; way0 wins.
- Read hit:
  - hit=1, stall=0.
  - Write the hit way's metadata with meta_din={tag,1,1} (MRU update).
- Write hit:
  - As a read hit, plus data_write to the hit way, word_enable=onehot(word), data_sel_mem=0.
- Write miss:
  - hit=0, stall=0. No allocation; memory write-through is handled outside this block.
- Read miss:
  - hit=0, stall=1.
  - Latch the address.
  - Victim selection, in priority order:
    - first invalid way (way0 first);
    - otherwise the way with lru=1;
    - if both lru bits are equal, way0.
  - Go to FILL.
- FILL:
  - Issue counter 0..7: mem_read_en=1 and mem_addr={tag,set,issue_cnt,1'b0} on each of the first 8 cycles.
  - Receive counter 0..7: each mem_data_valid writes the victim way, word_enable=onehot(recv_cnt), data_sel_mem=1.
  - After the 8th received word, go to COMMIT.
  - Counters wrap 7->0 and are cleared on entry to FILL.
- COMMIT:
  - One cycle: meta_write on the victim way, meta_din={tag,1,1}.
  - Go to IDLE; stall=0.
  - The re-presented request then hits.
- Ignored conditions:
  - mem_data_valid outside FILL.
  - req_valid/req_addr changes while stall=1; the latched address is used.
- Reset mid-FILL or mid-COMMIT: return to IDLE with no metadata write. The victim keeps its prior metadata; partially written data is harmless while that way's tag is not committed.

## Timing
- Reset values:
  - State IDLE, counters 0.
  - All outputs 0, except set_enable, which follows req_addr combinationally only when req_valid=1 and is otherwise 0.
- Hit: combinational, 0-cycle latency; the metadata/data write lands at the clock edge of the request cycle.
- Read miss (request in cycle 0):
  - mem_read_en in cycles 1-8.
  - mem_data_valid in cycles 1+MEM_LAT .. 8+MEM_LAT (5-12).
  - COMMIT in cycle 13; stall=1 through cycle 13.
  - hit in cycle 14.
- stall is a Moore output in FILL/COMMIT and a Mealy output in IDLE.

## Configuration
- CACHE_FILL_CTRL_STATS_EN defined:
  - Adds outputs hit_count and miss_count (16 bits each, saturating at 0xFFFF, cleared by rst).
  - They increment once per read hit in IDLE and once per read-miss entry to FILL.
- Not defined: the ports and counters are absent; all behaviour is otherwise identical.

## Structure
- Shared package cache_pkg holds:
  - TAG_W=6, SET_W=6, WORDS=8, MEM_LAT=4;
  - the metadata bit positions (TAG_MSB=7, LRU_BIT=1, VALID_BIT=0);
  - the state enum {IDLE, FILL, COMMIT}.
- One sub-module, cache_fill_seq, owns the issue/receive counters and mem_addr generation. Its outputs are done (8th word received) and the current word index.

## Test plan
- Cold read 0x1234 after reset (both ways invalid):
  - Miss, victim way0.
  - 8 reads at 0x1230..0x123E.
  - Metadata for set 0x23 = {0x04,1,1}.
  - Second lookup hits.
- Second tag in the same set, 0x5634:
  - Fills way1.
  - Then 0x1234 hits way0 and marks it MRU.
  - Then 0x9A34 misses and evicts way1, the LRU way.
- Write hit on word 3 of a resident block:
  - data_write on the hit way, word_enable=0x08, stall=0.
- Write miss:
  - No mem_read_en, stall=0, no metadata write.
- rst asserted in cycle 6 of a fill:
  - Outputs return to 0.
  - No meta_write.
  - The next access to that address misses again.
- With CACHE_FILL_CTRL_STATS_EN defined:
  - 3 misses then 5 hits -> miss_count=3, hit_count=5.
  - Forcing 0xFFFF hits keeps hit_count saturated at 0xFFFF.
